// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared types and default timing for the sdram arbiter
package sdram_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, REFRESH} state_t;
  typedef enum logic [1:0] {P0, P1, P2} port_t;

  localparam int SLOT_LEN_DEF         = 8;
  localparam int RD_LAT_DEF           = 5;
  localparam int REFRESH_INTERVAL_DEF = 500;

endpackage

// File: rtl/sdram_refresh_timer.sv
// rtl/sdram_refresh_timer.sv - free-running refresh interval counter with wrap pulse
module sdram_refresh_timer #(
  parameter int REFRESH_INTERVAL = 500
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic pulse
);

  localparam int CW = $clog2(REFRESH_INTERVAL);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_INTERVAL - 1);

  logic [CW-1:0] cnt;

  assign pulse = enable && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= pulse ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - three-port fixed-slot arbiter with auto-refresh in front of the sdram controller
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int SLOT_LEN         = SLOT_LEN_DEF,
  parameter int RD_LAT           = RD_LAT_DEF,
  parameter int REFRESH_INTERVAL = REFRESH_INTERVAL_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ram_ready,
  output logic        ram_cs,
  output logic        ram_we,
  output logic [21:0] ram_addr,
  output logic [1:0]  ram_ds,
  output logic [15:0] ram_din,
  input  logic [15:0] ram_dout,
  output logic        ram_refresh,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [21:0] p0_addr,
  input  logic [1:0]  p0_ds,
  input  logic [15:0] p0_din,
  output logic [15:0] p0_dout,
  output logic        p0_ack,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [21:0] p1_addr,
  input  logic [1:0]  p1_ds,
  input  logic [15:0] p1_din,
  output logic [15:0] p1_dout,
  output logic        p1_ack,
  input  logic        p2_req,
  input  logic        p2_we,
  input  logic [21:0] p2_addr,
  input  logic [1:0]  p2_ds,
  input  logic [15:0] p2_din,
  output logic [15:0] p2_dout,
  output logic        p2_ack
);

  localparam int CW = $clog2(SLOT_LEN);
  localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_LEN - 1);
  localparam logic [CW-1:0] CS_LAST   = CW'(SLOT_LEN - 3);
  localparam logic [CW-1:0] RD_AT     = CW'(RD_LAT);

  state_t        state;
  port_t         cur;
  port_t         rr_last;
  port_t         win;
  logic [CW-1:0] slot_cnt;
  logic          refresh_pend;
  logic          tick;
  logic          grant_point;
  logic          grant_ref;
  logic          grant_acc;
  logic          sel_we;
  logic [21:0]   sel_addr;
  logic [1:0]    sel_ds;
  logic [15:0]   sel_din;

  sdram_refresh_timer #(.REFRESH_INTERVAL(REFRESH_INTERVAL)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (ram_ready),
    .pulse   (tick)
  );

  // The last slot clock doubles as an IDLE clock so back-to-back slots stay SLOT_LEN apart.
  assign grant_point = (state == IDLE) || (slot_cnt == SLOT_LAST);

  always_comb begin
    grant_ref = 1'b0;
    grant_acc = 1'b0;
    win       = P0;
    if (ram_ready) begin
      if (refresh_pend) begin
        grant_ref = 1'b1;
      end else if (p0_req) begin
        grant_acc = 1'b1;
      end else if (p1_req && p2_req) begin
        grant_acc = 1'b1;
        win       = (rr_last == P1) ? P2 : P1;
      end else if (p1_req) begin
        grant_acc = 1'b1;
        win       = P1;
      end else if (p2_req) begin
        grant_acc = 1'b1;
        win       = P2;
      end
    end
  end

  always_comb begin
    sel_we   = p0_we;
    sel_addr = p0_addr;
    sel_ds   = p0_ds;
    sel_din  = p0_din;
    case (win)
      P1: begin
        sel_we = p1_we; sel_addr = p1_addr; sel_ds = p1_ds; sel_din = p1_din;
      end
      P2: begin
        sel_we = p2_we; sel_addr = p2_addr; sel_ds = p2_ds; sel_din = p2_din;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      slot_cnt     <= '0;
      cur          <= P0;
      rr_last      <= P2;
      refresh_pend <= 1'b0;
      ram_cs       <= 1'b0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_ds       <= '0;
      ram_din      <= '0;
      ram_refresh  <= 1'b0;
      p0_dout      <= '0;
      p1_dout      <= '0;
      p2_dout      <= '0;
      p0_ack       <= 1'b0;
      p1_ack       <= 1'b0;
      p2_ack       <= 1'b0;
    end else begin
      p0_ack <= 1'b0;
      p1_ack <= 1'b0;
      p2_ack <= 1'b0;
      // A wrap in the grant clock re-arms the request, so that refresh is not lost.
      refresh_pend <= (refresh_pend && !(grant_point && grant_ref)) || tick;

      if (state != IDLE) begin
        slot_cnt    <= slot_cnt + 1'b1;
        ram_cs      <= (state == ACCESS) && (slot_cnt < CS_LAST);
        ram_refresh <= (state == REFRESH) && (slot_cnt == '0);
        if (state == ACCESS && slot_cnt == RD_AT) begin
          case (cur)
            P0: begin p0_ack <= 1'b1; if (!ram_we) p0_dout <= ram_dout; end
            P1: begin p1_ack <= 1'b1; if (!ram_we) p1_dout <= ram_dout; end
            default: begin p2_ack <= 1'b1; if (!ram_we) p2_dout <= ram_dout; end
          endcase
        end
      end

      if (grant_point) begin
        if (grant_ref) begin
          state       <= REFRESH;
          slot_cnt    <= '0;
          ram_cs      <= 1'b0;
          ram_refresh <= 1'b1;
        end else if (grant_acc) begin
          state    <= ACCESS;
          slot_cnt <= '0;
          ram_cs   <= 1'b1;
          cur      <= win;
          ram_we   <= sel_we;
          ram_addr <= sel_addr;
          ram_ds   <= sel_ds;
          ram_din  <= sel_din;
          if (win != P0) rr_last <= win;
        end else if (state != IDLE) begin
          state    <= IDLE;
          slot_cnt <= '0;
        end
      end
    end
  end

endmodule
